fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Owns the program counter and sequences the instruction-fetch stage of the 5-stage MIPS-Lite pipeline. Each cycle it decides between sequential fetch, load-use stall, taken-branch redirect and halt. It drives the IF/ID write and flush controls. After a halt it drains the older in-flight instructions before parking the core. It also keeps fetch and stall statistics for the testbench and performance reporting.

## Interface
- ADDRESSWIDTH, 32, width of PC and branch address
- RESET_PC, 0, PC value loaded on reset
- DRAIN_CYCLES, 3, cycles spent in DRAIN after halt (EX, MEM, WB retire)
- CNTWIDTH, 32, width of statistics counters

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- haltSignal  in  1  HALT instruction currently in ID
- hazardDetected  in  1  load-use hazard; ID must hold
- branchTaken  in  1  older branch resolved taken this cycle
- branchAddress  in  ADDRESSWIDTH  branch target
- pc  out  ADDRESSWIDTH  current fetch address (registered)
- pcPlus4  out  ADDRESSWIDTH  pc + 4, modulo 2^ADDRESSWIDTH (combinational)
- fetchValid  out  1  instruction at pc is on the correct path and may be latched
- ifidWrite  out  1  IF/ID register load enable (combinational)
- ifidFlush  out  1  IF/ID register loads a bubble (combinational)
- draining  out  1  state is DRAIN
- halted  out  1  state is HALTED
- addrError  out  1  sticky; a misaligned branch target was seen
- fetchCount  out  CNTWIDTH  valid instructions latched into IF/ID
- stallCount  out  CNTWIDTH  cycles held by hazardDetected

## Operation
- States: IDLE, RUN, DRAIN, HALTED. Reset enters IDLE.
- Reset values: pc=RESET_PC; counters=0; addrError=0; drain counter=0.
- IDLE: lasts one cycle. pc holds. fetchValid=0, ifidWrite=0, ifidFlush=1. Next state is RUN.
- RUN priority is branchTaken > haltSignal > hazardDetected > sequential.
  - branchTaken: pc<=branchAddress with bits[1:0] forced to 0. addrError<=1 if those bits were nonzero. ifidWrite=1, ifidFlush=1, fetchValid=0. Any simultaneous halt or hazard is ignored; the younger instruction is wrong-path.
  - haltSignal (no branch): pc holds. ifidWrite=1, ifidFlush=1. Load drain counter with DRAIN_CYCLES. Go to DRAIN.
  - hazardDetected: pc holds. ifidWrite=0, ifidFlush=0. stallCount++.
  - Sequential: pc<=pcPlus4. ifidWrite=1, ifidFlush=0, fetchValid=1. fetchCount++.
- DRAIN: pc holds. ifidWrite=1, ifidFlush=1, fetchValid=0. All inputs are ignored. Drain counter decrements each cycle. The cycle it reads 1, the next state is HALTED. If DRAIN_CYCLES=0, go straight from RUN to HALTED.
- HALTED: terminal until reset. Outputs match DRAIN. Counters frozen.
- Counters saturate at all-ones and do not wrap.
- pc wraps modulo 2^ADDRESSWIDTH: 0xFFFFFFFC + 4 = 0x00000000. Wrap is not an error.

## Timing
- pc, counters, state and addrError are registered.
- ifidWrite, ifidFlush and fetchValid are combinational from state and inputs in the same cycle.
- Branch redirect: new pc is visible in the cycle after branchTaken. One bubble enters IF/ID.
- Stall: pc and IF/ID hold for exactly as many cycles as hazardDetected is high. No extra cycle after deassert.
- Halt: draining=1 from the cycle after haltSignal for DRAIN_CYCLES cycles. halted=1 from the next cycle onward.
- Asynchronous reset at any point, including mid-DRAIN or mid-stall: all outputs return to reset values immediately.
- Release of reset takes effect at the next rising edge.

## Test plan
- Reset release with RESET_PC=0: 1 IDLE cycle (fetchValid=0). Then pc steps 0,4,8,C. fetchCount=4 after 4 RUN cycles.
- hazardDetected high 2 cycles at pc=0x8: pc stays 0x8 for 2 cycles with ifidWrite=0. stallCount=2. Next cycle pc=0xC.
- branchTaken=1, hazardDetected=1, haltSignal=1 together, branchAddress=0x40: next pc=0x40, ifidFlush=1 that cycle, no DRAIN entry, stallCount unchanged.
- branchAddress=0x43: pc becomes 0x40, addrError=1 and stays 1 until reset.
- haltSignal at pc=0x20 with DRAIN_CYCLES=3: draining for 3 cycles, then halted=1. pc stays 0x20. Later hazard and branch inputs have no effect.
- Async reset asserted mid-DRAIN: pc=RESET_PC, draining=0, halted=0, counters=0 immediately. Sequence from IDLE restarts after release.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Program counter owner and IF-stage sequencer for the MIPS-Lite pipeline.
// Chooses between sequential fetch, stall, redirect and halt/drain each cycle.
module fetch_sequencer #(
    parameter int ADDRESSWIDTH = 32,
    parameter logic [ADDRESSWIDTH-1:0] RESET_PC = '0,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNTWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    haltSignal,
    input  logic                    hazardDetected,
    input  logic                    branchTaken,
    input  logic [ADDRESSWIDTH-1:0] branchAddress,
    output logic [ADDRESSWIDTH-1:0] pc,
    output logic [ADDRESSWIDTH-1:0] pcPlus4,
    output logic                    fetchValid,
    output logic                    ifidWrite,
    output logic                    ifidFlush,
    output logic                    draining,
    output logic                    halted,
    output logic                    addrError,
    output logic [CNTWIDTH-1:0]     fetchCount,
    output logic [CNTWIDTH-1:0]     stallCount
);

    localparam int DW = $clog2(DRAIN_CYCLES + 2);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } state_t;

    state_t        state;
    logic [DW-1:0] drainCnt;

    logic takeBr;
    logic takeHalt;
    logic takeStall;
    logic takeSeq;

    assign takeBr    = (state == RUN) && branchTaken;
    assign takeHalt  = (state == RUN) && !branchTaken && haltSignal;
    assign takeStall = (state == RUN) && !branchTaken && !haltSignal
                       && hazardDetected;
    assign takeSeq   = (state == RUN) && !branchTaken && !haltSignal
                       && !hazardDetected;

    assign pcPlus4  = pc + ADDRESSWIDTH'(4);
    assign draining = (state == DRAIN);
    assign halted   = (state == HALTED);

    // Redirect, halt, drain and halted all push a bubble into IF/ID.
    always_comb begin
        fetchValid = 1'b0;
        ifidWrite  = 1'b1;
        ifidFlush  = 1'b1;
        unique case (1'b1)
            (state == IDLE): ifidWrite = 1'b0;
            takeStall: begin
                ifidWrite = 1'b0;
                ifidFlush = 1'b0;
            end
            takeSeq: begin
                fetchValid = 1'b1;
                ifidFlush  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            drainCnt   <= '0;
            addrError  <= 1'b0;
            fetchCount <= '0;
            stallCount <= '0;
        end else begin
            unique case (state)
                IDLE: state <= RUN;
                RUN: begin
                    if (takeBr) begin
                        pc        <= {branchAddress[ADDRESSWIDTH-1:2], 2'b00};
                        addrError <= addrError | (|branchAddress[1:0]);
                    end else if (takeHalt) begin
                        drainCnt <= DW'(DRAIN_CYCLES);
                        state    <= (DRAIN_CYCLES == 0) ? HALTED : DRAIN;
                    end else if (takeStall) begin
                        if (stallCount != '1)
                            stallCount <= stallCount + 1'b1;
                    end else begin
                        pc <= pcPlus4;
                        if (fetchCount != '1)
                            fetchCount <= fetchCount + 1'b1;
                    end
                end
                DRAIN: begin
                    drainCnt <= drainCnt - 1'b1;
                    if (drainCnt == DW'(1))
                        state <= HALTED;
                end
                HALTED: state <= HALTED;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized + directed bench for fetch_sequencer against a cycle-count model.
// A second narrow-counter instance checks saturation.
module tb_fetch_sequencer;

    localparam int DC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        haltSignal, hazardDetected, branchTaken;
    logic [31:0] branchAddress;
    logic [31:0] pc, pcPlus4, fetchCount, stallCount;
    logic        fetchValid, ifidWrite, ifidFlush, draining, halted, addrError;
    logic [31:0] pc2, pcPlus42;
    logic        fv2, w2, f2, dr2, h2, ae2;
    logic [1:0]  fc2, sc2;

    int nvec = 0;
    int nerr = 0;

    // model
    logic [31:0] mPc, mFc, mSc;
    logic        mErr, mStarted;
    int          mAge;

    always #5 clk = ~clk;

    fetch_sequencer #(.ADDRESSWIDTH(32), .RESET_PC(32'h0),
                      .DRAIN_CYCLES(DC), .CNTWIDTH(32)) dut (
        .clk(clk), .reset(reset), .haltSignal(haltSignal),
        .hazardDetected(hazardDetected), .branchTaken(branchTaken),
        .branchAddress(branchAddress), .pc(pc), .pcPlus4(pcPlus4),
        .fetchValid(fetchValid), .ifidWrite(ifidWrite), .ifidFlush(ifidFlush),
        .draining(draining), .halted(halted), .addrError(addrError),
        .fetchCount(fetchCount), .stallCount(stallCount));

    fetch_sequencer #(.ADDRESSWIDTH(32), .RESET_PC(32'h0),
                      .DRAIN_CYCLES(DC), .CNTWIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .haltSignal(haltSignal),
        .hazardDetected(hazardDetected), .branchTaken(branchTaken),
        .branchAddress(branchAddress), .pc(pc2), .pcPlus4(pcPlus42),
        .fetchValid(fv2), .ifidWrite(w2), .ifidFlush(f2),
        .draining(dr2), .halted(h2), .addrError(ae2),
        .fetchCount(fc2), .stallCount(sc2));

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic logic [1:0] sat2(input logic [31:0] v);
        return (v > 32'd3) ? 2'd3 : v[1:0];
    endfunction

    task automatic model_reset();
        mPc = 32'h0; mFc = 0; mSc = 0; mErr = 0; mStarted = 0; mAge = 0;
    endtask

    // Compare all outputs against the model for the current inputs.
    task automatic compare();
        logic xv, xw, xf;
        if (reset || !mStarted) begin
            xv = 0; xw = 0; xf = 1;
        end else if (mAge > 0 || branchTaken || haltSignal) begin
            xv = 0; xw = 1; xf = 1;
        end else if (hazardDetected) begin
            xv = 0; xw = 0; xf = 0;
        end else begin
            xv = 1; xw = 1; xf = 0;
        end
        chk("pc", pc, mPc);
        chk("pcPlus4", pcPlus4, mPc + 32'd4);
        chk("fetchValid", 32'(fetchValid), 32'(xv));
        chk("ifidWrite", 32'(ifidWrite), 32'(xw));
        chk("ifidFlush", 32'(ifidFlush), 32'(xf));
        chk("draining", 32'(draining), 32'(mAge >= 1 && mAge <= DC));
        chk("halted", 32'(halted), 32'(mAge > DC));
        chk("addrError", 32'(addrError), 32'(mErr));
        chk("fetchCount", fetchCount, mFc);
        chk("stallCount", stallCount, mSc);
        chk("fetchCount_sat", 32'(fc2), 32'(sat2(mFc)));
        chk("stallCount_sat", 32'(sc2), 32'(sat2(mSc)));
    endtask

    task automatic model_edge();
        if (!mStarted) mStarted = 1;
        else if (mAge > 0) begin
            if (mAge < 1000) mAge++;
        end else if (branchTaken) begin
            mPc  = branchAddress & 32'hFFFF_FFFC;
            mErr = mErr | (branchAddress[1:0] != 2'b00);
        end else if (haltSignal) mAge = 1;
        else if (hazardDetected) mSc++;
        else begin
            mPc = mPc + 32'd4;
            mFc++;
        end
    endtask

    // Called at a negedge: drive, check, clock, update model.
    task automatic step(input logic br, input logic [31:0] addr,
                        input logic hl, input logic hz);
        branchTaken = br; branchAddress = addr;
        haltSignal = hl; hazardDetected = hz;
        #1 compare();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        branchTaken = 0; branchAddress = 0; haltSignal = 0; hazardDetected = 0;
        model_reset();
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        chk("rst_fetchCount", fetchCount, 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        step(0, 0, 0, 0);
        chk("idle_pc", pc, 32'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("seq_pc8", pc, 32'h8);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("stall_pc", pc, 32'h8);
        chk("stall_cnt", stallCount, 32'd2);
        step(0, 0, 0, 0);
        chk("after_stall_pc", pc, 32'hC);
        step(0, 0, 0, 0);
        chk("fc4", fetchCount, 32'd4);
        step(1, 32'h40, 1, 1);
        chk("br_pc", pc, 32'h40);
        chk("br_nodrain", 32'(draining), 32'h0);
        chk("br_stall", stallCount, 32'd2);
        step(1, 32'h43, 0, 0);
        chk("misal_pc", pc, 32'h40);
        chk("misal_err", 32'(addrError), 32'h1);
        step(1, 32'h20, 0, 0);
        step(0, 0, 1, 0);
        chk("drain1", 32'(draining), 32'h1);
        step(1, 32'h80, 0, 1);
        step(1, 32'h80, 1, 1);
        chk("drain3", 32'(draining), 32'h1);
        step(1, 32'h80, 0, 0);
        chk("halted", 32'(halted), 32'h1);
        chk("halted_pc", pc, 32'h20);
        chk("err_sticky", 32'(addrError), 32'h1);
        repeat (3) step(1, 32'h100, 0, 1);

        do_reset();
        repeat (3) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        do_reset();
        chk("midrain_pc", pc, 32'h0);
        chk("midrain_dr", 32'(draining), 32'h0);
        chk("midrain_fc", fetchCount, 32'h0);

        step(0, 0, 0, 0);
        step(1, 32'hFFFF_FFF8, 0, 0);
        step(0, 0, 0, 0);
        chk("pc_fc", pc, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_err", 32'(addrError), 32'h0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) do_reset();
            else step($urandom_range(0, 9) == 0, $urandom,
                      $urandom_range(0, 59) == 0,
                      $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
